// File: rtl/score_pkg.sv
// Shared types and helpers for the score/lives game-flow controller.
package score_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    BALL_LOST = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  typedef logic [3:0] bcd_digit_t;

  // All-9s BCD pattern for up to 16 digits; callers slice the low 4*digits bits.
  function automatic logic [63:0] bcdAllNines(input int digits);
    logic [63:0] nines;
    nines = '0;
    for (int d = 0; d < 16; d++) begin
      if (d < digits) nines[4*d +: 4] = 4'd9;
    end
    return nines;
  endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Combinational multi-digit BCD add/subtract of a single-digit operand.
// Overflow saturates at all-9s, underflow clamps at zero.
module bcd_add_sat
  import score_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] valueIn,
  input  bcd_digit_t          operand,
  input  logic                subtract,
  output logic [4*DIGITS-1:0] valueOut
);

  localparam int W = 4 * DIGITS;
  localparam logic [63:0] NINES64 = bcdAllNines(DIGITS);
  localparam logic [W-1:0] ALL_NINES = NINES64[W-1:0];

  logic [W-1:0] raw;
  logic [4:0]   acc;
  logic         carry;
  bcd_digit_t   digitA;
  bcd_digit_t   digitB;

  // Ripple decimal carry/borrow through the digits; a leftover carry means out of range.
  always_comb begin
    raw    = '0;
    acc    = '0;
    carry  = 1'b0;
    digitA = '0;
    digitB = '0;
    for (int d = 0; d < DIGITS; d++) begin
      digitA = valueIn[4*d +: 4];
      digitB = (d == 0) ? operand : 4'd0;
      if (!subtract) begin
        acc = {1'b0, digitA} + {1'b0, digitB} + {4'b0000, carry};
        if (acc > 5'd9) begin
          acc   = acc - 5'd10;
          carry = 1'b1;
        end else begin
          carry = 1'b0;
        end
      end else begin
        acc = {1'b0, digitA} - {1'b0, digitB} - {4'b0000, carry};
        // Negative results wrap into 22..31, so bit 4 flags a borrow.
        if (acc[4]) begin
          acc   = acc + 5'd10;
          carry = 1'b1;
        end else begin
          carry = 1'b0;
        end
      end
      raw[4*d +: 4] = acc[3:0];
    end
    if (carry) valueOut = subtract ? '0 : ALL_NINES;
    else       valueOut = raw;
  end

endmodule

// File: rtl/score_lives_controller.sv
// Game-flow controller: BCD score, remaining lives, ball-loss handling.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IDLE      | after reset, waiting for startGame
//   PLAYING   | scoring active, watching for the ball reaching the bottom
//   BALL_LOST | ball lost, counting LOST_FRAMES frames before relaunch
//   GAME_OVER | no lives left, score/lives frozen until startGame
module score_lives_controller
  import score_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int INIT_LIVES    = 3,
  parameter int GOOD_POINTS   = 5,
  parameter int BAD_POINTS    = 3,
  parameter int BUMPER_POINTS = 1,
  parameter int LOST_FRAMES   = 60
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                startOfFrame,
  input  logic                startGame,
  input  logic                collisionSmileyObstacleGood,
  input  logic                collisionSmileyObstacleBad,
  input  logic                collisionSmileyBumperPulse,
  input  logic                collisionSmileyBottom,
  output logic [4*DIGITS-1:0] score,
  output logic [2:0]          lives,
  output logic                gameActive,
  output logic                ballRelaunch,
  output logic                gameOver
);

  localparam int W = 4 * DIGITS;
  localparam bcd_digit_t GOOD_D   = 4'(GOOD_POINTS);
  localparam bcd_digit_t BAD_D    = 4'(BAD_POINTS);
  localparam bcd_digit_t BUMPER_D = 4'(BUMPER_POINTS);
  localparam logic [2:0] INIT_L   = 3'(INIT_LIVES);
  localparam logic [7:0] LOST_CNT = 8'(LOST_FRAMES);

  game_state_t  state;
  logic [7:0]   frameCnt;
  logic         bottomSeen;
  bcd_digit_t   addTerm;
  bcd_digit_t   subTerm;
  logic [W-1:0] scoreAdded;
  logic [W-1:0] scoreNext;
  logic         anyHit;
  logic         ballLoss;

  // Per-cycle score deltas; GOOD_POINTS + BUMPER_POINTS is assumed to fit one BCD digit.
  always_comb begin
    addTerm = (collisionSmileyObstacleGood ? GOOD_D : 4'd0)
            + (collisionSmileyBumperPulse  ? BUMPER_D : 4'd0);
    subTerm = collisionSmileyObstacleBad ? BAD_D : 4'd0;
    anyHit  = collisionSmileyObstacleGood | collisionSmileyObstacleBad
            | collisionSmileyBumperPulse;
    ballLoss = collisionSmileyBottom & ~bottomSeen;
  end

  bcd_add_sat #(.DIGITS(DIGITS)) addStage (
    .valueIn  (score),
    .operand  (addTerm),
    .subtract (1'b0),
    .valueOut (scoreAdded)
  );

  bcd_add_sat #(.DIGITS(DIGITS)) subStage (
    .valueIn  (scoreAdded),
    .operand  (subTerm),
    .subtract (1'b1),
    .valueOut (scoreNext)
  );

  // Game-flow FSM with registered score, lives and relaunch pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      score        <= '0;
      lives        <= INIT_L;
      frameCnt     <= '0;
      bottomSeen   <= 1'b0;
      ballRelaunch <= 1'b0;
    end else begin
      ballRelaunch <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (startGame) begin
            state        <= PLAYING;
            score        <= '0;
            lives        <= INIT_L;
            frameCnt     <= '0;
            bottomSeen   <= 1'b0;
            ballRelaunch <= 1'b1;
          end
        end
        PLAYING: begin
          if (anyHit) score <= scoreNext;
          if (startOfFrame) bottomSeen <= 1'b0;
          if (ballLoss) begin
            bottomSeen <= 1'b1;
            lives      <= (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            frameCnt   <= '0;
            state      <= BALL_LOST;
          end
        end
        BALL_LOST: begin
          if (frameCnt == LOST_CNT) begin
            if (lives == 3'd0) begin
              state <= GAME_OVER;
            end else begin
              state        <= PLAYING;
              ballRelaunch <= 1'b1;
              bottomSeen   <= 1'b0;
            end
          end else if (startOfFrame) begin
            frameCnt <= frameCnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign gameActive = (state == PLAYING);
  assign gameOver   = (state == GAME_OVER);

endmodule

// File: doc/score_lives_controller.md
Name: score_lives_controller

Overview:
- Sits directly downstream of the collision detector and consumes its per-frame collision pulses.
- Maintains the BCD score and the remaining-lives counter, and runs the game-flow state machine (idle, playing, ball lost, game over).
- Drives the score display, the ball relaunch request to the smiley/ball mover, and the game status flags.
- All event inputs are sampled on clk; the block is frame-aware through startOfFrame.

Parameters:
DIGITS, 4, number of BCD score digits; score saturates at all-9s.
INIT_LIVES, 3, lives loaded on game start (1..7).
GOOD_POINTS, 5, points added per good-obstacle hit (BCD-representable, < 10).
BAD_POINTS, 3, points subtracted per bad-obstacle hit (< 10).
BUMPER_POINTS, 1, points added per bumper hit (< 10).
LOST_FRAMES, 60, frames spent in BALL_LOST before relaunch or game over (1..255).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at each frame start
startGame  in  1  level, start/restart request (key); acted on when high
collisionSmileyObstacleGood  in  1  one-cycle pulse, good obstacle hit
collisionSmileyObstacleBad  in  1  one-cycle pulse, bad obstacle hit
collisionSmileyBumperPulse  in  1  one-cycle pulse, bumper hit
collisionSmileyBottom  in  1  level, smiley overlapping bottom region this pixel
score  out  4*DIGITS  BCD score, digit 0 in bits [3:0]
lives  out  3  remaining lives, binary
gameActive  out  1  high in PLAYING
ballRelaunch  out  1  one-cycle pulse requesting ball reset to launch position
gameOver  out  1  high in GAME_OVER

Behaviour:
- Reset (async, active-high):
  - state=IDLE, score=0, lives=INIT_LIVES.
  - frameCnt=0, bottomSeen=0.
  - ballRelaunch=0, gameActive=0, gameOver=0.
- The FSM has four states.
- IDLE:
  - On startGame=1: go to PLAYING next cycle; load score=0 and lives=INIT_LIVES; pulse ballRelaunch in that same transition cycle.
  - Collision inputs are ignored.
- PLAYING:
  - Scoring is registered, 1-cycle latency. In a cycle with collision pulses: delta = Good*GOOD_POINTS + Bumper*BUMPER_POINTS - Bad*BAD_POINTS.
  - Good and Bad are mutually exclusive by construction. Bumper may coincide with either; both contributions apply in the same cycle.
  - Arithmetic is decimal (BCD). The result saturates at all-9s on overflow and clamps at 0 on underflow.
  - Bottom detection: collisionSmileyBottom is a level signal.
    - The first cycle with it high while bottomSeen=0 counts as a ball loss and sets bottomSeen.
    - bottomSeen clears on startOfFrame, so at most one loss per frame.
  - On ball loss: lives decrements (never below 0), frameCnt=0, state goes to BALL_LOST.
  - If a scoring pulse coincides with the loss cycle, the score update still applies.
- BALL_LOST:
  - Scoring and bottom inputs are ignored.
  - frameCnt increments on each startOfFrame.
  - When frameCnt reaches LOST_FRAMES:
    - lives=0 → GAME_OVER.
    - otherwise → PLAYING, pulse ballRelaunch for one cycle, clear bottomSeen.
- GAME_OVER:
  - score and lives hold.
  - On startGame=1: behave as IDLE start (load, relaunch, PLAYING).
- startGame in PLAYING or BALL_LOST is ignored; there is no mid-game restart.
- Outputs are registered. gameActive and gameOver are decoded from the state register.
- Reset asserted mid-game returns to IDLE immediately (asynchronous); no pending pulse survives.

Decomposition:
- Package score_pkg holds:
  - game_state_t enum {IDLE, PLAYING, BALL_LOST, GAME_OVER};
  - the BCD digit typedef;
  - the BCD all-9s constant function for DIGITS.
- Sub-module bcd_add_sat: combinational DIGITS-wide BCD add/subtract of a single-digit value, with saturation at all-9s and clamp at 0.
  - Instantiated twice: once for the add term, once for the subtract term, chained.

Test Plan:
- Reset then startGame pulse → ballRelaunch high exactly 1 cycle; gameActive=1, score=0x0000, lives=3.
- In PLAYING: Good pulse, then Bumper pulse, then Bad pulse, 2 cycles apart → score 0x0005, then 0x0006, then 0x0003. Good and Bumper in the same cycle → +6.
- Score 0x9997 plus Good → 0x9999 (saturate). Score 0x0002 plus Bad → 0x0000 (clamp).
- collisionSmileyBottom held high 500 cycles within one frame → lives decrements by exactly 1, state BALL_LOST. After LOST_FRAMES startOfFrame pulses → ballRelaunch pulse, back in PLAYING.
- Three ball losses from lives=3 → lives=0, gameOver=1 after LOST_FRAMES frames, score held. Further collision pulses leave score unchanged. startGame → score=0, lives=3, PLAYING.
- Assert reset during BALL_LOST mid-count → all outputs return to reset values that cycle, state IDLE, no ballRelaunch pulse after release.
